note_voice_allocator: RTL and testbench

- Parametrised successor to the fixed 10-key note front end.
- Synchronises and debounces NUM_KEYS raw key lines, detects press and release edges, and assigns pressed keys to NUM_VOICES polyphonic voices, stealing the oldest voice when all are busy.
- Owns a saturating pitch-shift register driven by up/down pulses.
- Sits between the key pins and modeselect/tone generation; voice outputs replace the flat 10-bit note bus.

---
 rtl/note_voice_allocator.sv | 200 ++++++++++++++++++++
 tb/tb_note_voice_allocator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_voice_allocator.sv
// Key debounce, edge scan and oldest-steal voice allocation with pitchshift.
// Define NOTE_VOICE_SUSTAIN_EN to add the sustain input.
module note_voice_allocator #(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_VOICES = 4,
    parameter int DB_COUNT   = 255,
    parameter int DB_WIDTH   = 8,
    parameter int SHIFT_W    = 5,
    parameter int SHIFT_MAX  = 24,
    parameter int SHIFT_INIT = 12,
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_KEYS-1:0]      key_in,
    input  logic                     shift_up,
    input  logic                     shift_dn,
    input  logic                     shift_clr,
`ifdef NOTE_VOICE_SUSTAIN_EN
    input  logic                     sustain,
`endif
    output logic [NUM_KEYS-1:0]      held,
    output logic [NUM_VOICES-1:0]    voice_active,
    output logic [NUM_VOICES*KW-1:0] voice_key,
    output logic                     ev_valid,
    output logic                     ev_on,
    output logic                     ev_steal,
    output logic [VW-1:0]            ev_voice,
    output logic [KW-1:0]            ev_key,
    output logic [SHIFT_W-1:0]       pitchshift
);

    logic [NUM_KEYS-1:0]   sync1, sync2;
    logic [NUM_KEYS-1:0]   pend_on, pend_off;
    logic [NUM_KEYS-1:0]   tog;
    logic [DB_WIDTH-1:0]   db_cnt [NUM_KEYS];
    logic [KW-1:0]         scan_p;
    logic [VW-1:0]         age [NUM_VOICES];
    logic [NUM_VOICES-1:0] sus;
    logic                  sus_lvl;

`ifdef NOTE_VOICE_SUSTAIN_EN
    assign sus_lvl = sustain;
`else
    assign sus_lvl = 1'b0;
`endif

    logic          do_off, do_on, flush;
    logic          hit, any_free, any_sus;
    logic [VW-1:0] hit_v, free_v, old_v, flush_v, alloc_v;
    logic [VW-1:0] best_age;

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            tog[k] = (sync2[k] != held[k]) &&
                     (db_cnt[k] == DB_WIDTH'(DB_COUNT));
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_v    = '0;
        any_free = 1'b0;
        free_v   = '0;
        any_sus  = 1'b0;
        flush_v  = '0;
        old_v    = '0;
        best_age = age[0];
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_active[v] && voice_key[v*KW +: KW] == scan_p) begin
                hit   = 1'b1;
                hit_v = VW'(v);
            end
            if (!voice_active[v]) begin
                any_free = 1'b1;
                free_v   = VW'(v);
            end
            if (sus[v]) begin
                any_sus = 1'b1;
                flush_v = VW'(v);
            end
        end
        // strict compare keeps the lowest index on equal ages
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v] > best_age) begin
                best_age = age[v];
                old_v    = VW'(v);
            end
        end
        alloc_v = hit ? hit_v : (any_free ? free_v : old_v);
        flush   = !sus_lvl && any_sus;
        do_off  = pend_off[scan_p];
        do_on   = !pend_off[scan_p] && pend_on[scan_p];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= '0;
            sync2        <= '0;
            held         <= '0;
            pend_on      <= '0;
            pend_off     <= '0;
            scan_p       <= '0;
            sus          <= '0;
            voice_active <= '0;
            voice_key    <= '0;
            ev_valid     <= 1'b0;
            ev_on        <= 1'b0;
            ev_steal     <= 1'b0;
            ev_voice     <= '0;
            ev_key       <= '0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
            for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync2[k] == held[k]) begin
                    db_cnt[k] <= '0;
                end else if (tog[k]) begin
                    db_cnt[k] <= '0;
                    held[k]   <= ~held[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end

            scan_p <= (scan_p == KW'(NUM_KEYS - 1)) ? '0 : scan_p + 1'b1;

            ev_valid <= 1'b0;
            ev_on    <= 1'b0;
            ev_steal <= 1'b0;
            ev_voice <= '0;
            ev_key   <= '0;

            // sustain flush pre-empts the scan; pend flags stay put
            if (flush) begin
                voice_active[flush_v] <= 1'b0;
                sus[flush_v]          <= 1'b0;
                ev_valid              <= 1'b1;
                ev_voice              <= flush_v;
                ev_key                <= voice_key[flush_v*KW +: KW];
            end else if (do_off) begin
                pend_off[scan_p] <= 1'b0;
                if (hit && sus_lvl) begin
                    sus[hit_v] <= 1'b1;
                end else if (hit) begin
                    voice_active[hit_v] <= 1'b0;
                    ev_valid            <= 1'b1;
                    ev_voice            <= hit_v;
                    ev_key              <= scan_p;
                end
            end else if (do_on) begin
                pend_on[scan_p]              <= 1'b0;
                voice_active[alloc_v]        <= 1'b1;
                voice_key[alloc_v*KW +: KW]  <= scan_p;
                sus[alloc_v]                 <= 1'b0;
                ev_valid                     <= 1'b1;
                ev_on                        <= 1'b1;
                ev_steal                     <= !hit && !any_free;
                ev_voice                     <= alloc_v;
                ev_key                       <= scan_p;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (VW'(v) == alloc_v) begin
                        age[v] <= '0;
                    end else if (voice_active[v] &&
                                 age[v] != VW'(NUM_VOICES - 1)) begin
                        age[v] <= age[v] + 1'b1;
                    end
                end
            end

            // new edges win over same-cycle scan clears
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (tog[k] && held[k]) begin
                    pend_off[k] <= 1'b1;
                    pend_on[k]  <= 1'b0;
                end else if (tog[k]) begin
                    pend_on[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pitchshift <= SHIFT_W'(SHIFT_INIT);
        end else if (shift_clr) begin
            pitchshift <= SHIFT_W'(SHIFT_INIT);
        end else if (shift_up && shift_dn) begin
            pitchshift <= pitchshift;
        end else if (shift_up) begin
            if (pitchshift != SHIFT_W'(SHIFT_MAX)) pitchshift <= pitchshift + 1'b1;
        end else if (shift_dn) begin
            if (pitchshift != '0) pitchshift <= pitchshift - 1'b1;
        end
    end

endmodule

// File: tb/tb_note_voice_allocator.sv
// Directed bench for note_voice_allocator with DB_COUNT=3.
// Sustain steps run only when NOTE_VOICE_SUSTAIN_EN is defined.
module tb_note_voice_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  key_in;
    logic        shift_up, shift_dn, shift_clr;
    logic [9:0]  held;
    logic [3:0]  voice_active;
    logic [15:0] voice_key;
    logic        ev_valid, ev_on, ev_steal;
    logic [1:0]  ev_voice;
    logic [3:0]  ev_key;
    logic [4:0]  pitchshift;
`ifdef NOTE_VOICE_SUSTAIN_EN
    logic        sustain;
`endif

    note_voice_allocator #(
        .NUM_KEYS(10), .NUM_VOICES(4), .DB_COUNT(3), .DB_WIDTH(8),
        .SHIFT_W(5), .SHIFT_MAX(24), .SHIFT_INIT(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .shift_up(shift_up), .shift_dn(shift_dn), .shift_clr(shift_clr),
`ifdef NOTE_VOICE_SUSTAIN_EN
        .sustain(sustain),
`endif
        .held(held), .voice_active(voice_active), .voice_key(voice_key),
        .ev_valid(ev_valid), .ev_on(ev_on), .ev_steal(ev_steal),
        .ev_voice(ev_voice), .ev_key(ev_key), .pitchshift(pitchshift)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       on;
        logic       steal;
        logic [1:0] voice;
        logic [3:0] key;
        int         cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ev_valid === 1'b1)
            evq.push_back('{ev_on, ev_steal, ev_voice, ev_key, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which, input int n);
        repeat (n) begin
            shift_up  = (which == 0);
            shift_dn  = (which == 1);
            shift_clr = (which == 2);
            if (which == 3) begin
                shift_up = 1'b1;
                shift_dn = 1'b1;
            end
            step(1);
            shift_up  = 1'b0;
            shift_dn  = 1'b0;
            shift_clr = 1'b0;
        end
    endtask

    // drive one key then allow debounce + a full scan pass
    task automatic key(input int k, input logic val);
        key_in[k] = val;
        step(20);
    endtask

    // expect exactly one queued event with the given fields
    task automatic expect_ev(input string tag, input logic on,
                             input logic steal, input logic [1:0] v,
                             input logic [3:0] k);
        ev_t e;
        check({tag, "_count"}, evq.size(), 1);
        if (evq.size() != 0) begin
            e = evq.pop_front();
            check({tag, "_on"}, e.on, on);
            check({tag, "_steal"}, e.steal, steal);
            check({tag, "_voice"}, e.voice, v);
            check({tag, "_key"}, e.key, k);
        end
        evq.delete();
    endtask

    initial begin
        ev_t e0, e1;
        rst_n     = 1'b0;
        key_in    = '0;
        shift_up  = 1'b0;
        shift_dn  = 1'b0;
        shift_clr = 1'b0;
`ifdef NOTE_VOICE_SUSTAIN_EN
        sustain   = 1'b0;
`endif
        step(3);
        check("rst_held", held, 0);
        check("rst_active", voice_active, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_pitch", pitchshift, 12);
        rst_n = 1'b1;
        step(2);

        key_in[3] = 1'b1;
        step(5);
        check("db_held_early", held, 0);
        step(1);
        check("db_held_on", held, 10'h008);
        for (int i = 0; i < 12; i++) begin
            if (evq.size() == 0) step(1);
        end
        expect_ev("press3", 1'b1, 1'b0, 2'd0, 4'd3);
        check("press3_active", voice_active, 4'b0001);
        check("press3_vkey", voice_key[3:0], 3);

        key_in[2] = 1'b1;
        step(2);
        key_in[2] = 1'b0;
        step(20);
        check("glitch_held", held, 10'h008);
        check("glitch_no_ev", evq.size(), 0);

        key(3, 1'b0);
        expect_ev("rel3", 1'b0, 1'b0, 2'd0, 4'd3);
        check("rel3_active", voice_active, 0);

        key(1, 1'b1);
        expect_ev("press1", 1'b1, 1'b0, 2'd0, 4'd1);
        key(2, 1'b1);
        expect_ev("press2", 1'b1, 1'b0, 2'd1, 4'd2);
        key(4, 1'b1);
        expect_ev("press4", 1'b1, 1'b0, 2'd2, 4'd4);
        key(5, 1'b1);
        expect_ev("press5", 1'b1, 1'b0, 2'd3, 4'd5);
        check("full_active", voice_active, 4'b1111);

        key(7, 1'b1);
        expect_ev("steal7", 1'b1, 1'b1, 2'd0, 4'd7);
        check("steal7_vkey", voice_key[3:0], 7);

        key(1, 1'b0);
        check("stolen_rel_no_ev", evq.size(), 0);
        check("stolen_rel_active", voice_active, 4'b1111);

        key(2, 1'b0);
        expect_ev("rel2", 1'b0, 1'b0, 2'd1, 4'd2);
        check("rel2_active", voice_active, 4'b1101);
        key(9, 1'b1);
        expect_ev("press9", 1'b1, 1'b0, 2'd1, 4'd9);
        check("press9_vkey", voice_key[7:4], 9);

        key_in = '0;
        rst_n  = 1'b0;
        step(1);
        check("midrst_active", voice_active, 0);
        check("midrst_held", held, 0);
        step(2);
        rst_n = 1'b1;
        step(20);
        check("midrst_no_ev", evq.size(), 0);

        pulse(0, 1);
        check("shift_up1", pitchshift, 13);
        pulse(0, 12);
        check("shift_sat_hi", pitchshift, 24);
        pulse(3, 1);
        check("shift_both_hold", pitchshift, 24);
        pulse(2, 1);
        check("shift_clr", pitchshift, 12);
        pulse(1, 13);
        check("shift_sat_lo", pitchshift, 0);

`ifdef NOTE_VOICE_SUSTAIN_EN
        sustain = 1'b1;
        key(0, 1'b1);
        expect_ev("sus_press0", 1'b1, 1'b0, 2'd0, 4'd0);
        key(1, 1'b1);
        expect_ev("sus_press1", 1'b1, 1'b0, 2'd1, 4'd1);
        key(0, 1'b0);
        key(1, 1'b0);
        check("sus_no_off", evq.size(), 0);
        check("sus_active", voice_active, 4'b0011);
        sustain = 1'b0;
        step(5);
        check("flush_count", evq.size(), 2);
        if (evq.size() == 2) begin
            e0 = evq.pop_front();
            e1 = evq.pop_front();
            check("flush0_on", e0.on, 0);
            check("flush0_voice", e0.voice, 0);
            check("flush1_on", e1.on, 0);
            check("flush1_voice", e1.voice, 1);
            check("flush_adjacent", e1.cyc, e0.cyc + 1);
        end
        evq.delete();
        check("flush_active", voice_active, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
